// File: rtl/ysyx_22040237_core_ctrl_pkg.sv
// Shared state encoding, halt codes and reset vector for the ysyx_22040237 core sequencer.
package ysyx_22040237_core_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF_REQ   = 3'd0,
      S_IF_WAIT  = 3'd1,
      S_EX       = 3'd2,
      S_MEM_REQ  = 3'd3,
      S_MEM_WAIT = 3'd4,
      S_WB       = 3'd5,
      S_HALT     = 3'd6
   } state_e;

   localparam logic [1:0]  HALT_RUN     = 2'd0;
   localparam logic [1:0]  HALT_EBREAK  = 2'd1;
   localparam logic [1:0]  HALT_ILLEGAL = 2'd2;
   localparam logic [1:0]  HALT_TIMEOUT = 2'd3;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   // States that wait on an external handshake and therefore feed the watchdog.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_IF_REQ) || (s == S_IF_WAIT) || (s == S_MEM_REQ) || (s == S_MEM_WAIT);
   endfunction

endpackage

// File: rtl/ysyx_22040237_core_ctrl_perf_cnt.sv
// 64-bit free-running performance counter with synchronous clear and count enable; wraps silently.
module ysyx_22040237_perf_cnt (
   input  logic        clk,
   input  logic        i_clr,
   input  logic        i_en,
   output logic [63:0] o_cnt
);

   logic [63:0] r_cnt;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 64'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_22040237_core_ctrl.sv
// Multi-cycle NPC sequencer: fetch handshake, decode/execute, optional data access, commit, halt.
// Owns the FSM, the handshake watchdog, the PC/instruction registers and the perf counters.
module ysyx_22040237_core_ctrl
   import ysyx_22040237_core_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] inst,
   output logic [31:0] pc,
   input  logic [7:0]  dec_opcode,
   input  logic        dec_ebreak,
   input  logic        dec_jump,
   input  logic        dec_mem,
   input  logic        dec_rd_w_en,
   input  logic [31:0] jump_target,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   input  logic        dmem_resp_valid,
   output logic        rf_w_en,
   output logic        halt,
   output logic [1:0]  halt_code,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instret_cnt
);

   localparam int unsigned     WD_W    = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_e          r_state;
   state_e          w_next_state;
   logic [1:0]      w_halt_code;
   logic [WD_W-1:0] r_wd;
   logic [31:0]     r_pc;
   logic [31:0]     r_inst;
   logic            r_halt;
   logic [1:0]      r_halt_code;
   logic            w_wd_expired;
   logic            w_enter_halt;

   assign w_wd_expired = (r_wd == WD_LAST);
   assign w_enter_halt = (w_next_state == S_HALT) && (r_state != S_HALT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IF_REQ;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; a handshake completing in the expiry cycle takes precedence over timeout.
   always_comb begin
      w_next_state = r_state;
      w_halt_code  = HALT_RUN;
      case (r_state)
         S_IF_REQ: begin
            if (imem_req_ready) begin
               w_next_state = S_IF_WAIT;
            end else if (w_wd_expired) begin
               w_next_state = S_HALT;
               w_halt_code  = HALT_TIMEOUT;
            end
         end
         S_IF_WAIT: begin
            if (imem_resp_valid) begin
               w_next_state = S_EX;
            end else if (w_wd_expired) begin
               w_next_state = S_HALT;
               w_halt_code  = HALT_TIMEOUT;
            end
         end
         S_EX: begin
            if (dec_ebreak) begin
               w_next_state = S_HALT;
               w_halt_code  = HALT_EBREAK;
            end else if (dec_opcode == 8'h00) begin
               w_next_state = S_HALT;
               w_halt_code  = HALT_ILLEGAL;
            end else if (dec_jump && jump_target[1]) begin
               w_next_state = S_HALT;
               w_halt_code  = HALT_ILLEGAL;
            end else if (dec_mem) begin
               w_next_state = S_MEM_REQ;
            end else begin
               w_next_state = S_WB;
            end
         end
         S_MEM_REQ: begin
            if (dmem_req_ready) begin
               w_next_state = S_MEM_WAIT;
            end else if (w_wd_expired) begin
               w_next_state = S_HALT;
               w_halt_code  = HALT_TIMEOUT;
            end
         end
         S_MEM_WAIT: begin
            if (dmem_resp_valid) begin
               w_next_state = S_WB;
            end else if (w_wd_expired) begin
               w_next_state = S_HALT;
               w_halt_code  = HALT_TIMEOUT;
            end
         end
         S_WB:    w_next_state = S_IF_REQ;
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_IF_REQ;
      endcase
   end

   // Output decode
   always_comb begin
      imem_req_valid = (r_state == S_IF_REQ);
      dmem_req_valid = (r_state == S_MEM_REQ);
      rf_w_en        = (r_state == S_WB) && dec_rd_w_en;
   end

   // Watchdog, PC, instruction latch and halt status
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd        <= '0;
         r_pc        <= RESET_PC;
         r_inst      <= '0;
         r_halt      <= 1'b0;
         r_halt_code <= HALT_RUN;
      end else begin
         if (w_next_state != r_state) begin
            r_wd <= '0;
         end else if (is_wait_state(r_state)) begin
            r_wd <= r_wd + 1'b1;
         end

         if ((r_state == S_IF_WAIT) && imem_resp_valid) begin
            r_inst <= imem_resp_data;
         end

         if (r_state == S_WB) begin
            r_pc <= dec_jump ? (jump_target & 32'hFFFF_FFFE) : (r_pc + 32'd4);
         end

         if (w_enter_halt) begin
            r_halt      <= 1'b1;
            r_halt_code <= w_halt_code;
         end
      end
   end

   ysyx_22040237_perf_cnt u_cycle_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (r_state != S_HALT),
      .o_cnt (cycle_cnt)
   );

   ysyx_22040237_perf_cnt u_instret_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (r_state == S_WB),
      .o_cnt (instret_cnt)
   );

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign inst      = r_inst;
   assign halt      = r_halt;
   assign halt_code = r_halt_code;

endmodule

// File: tb/tb_ysyx_22040237_core_ctrl.sv
// Directed bench for ysyx_22040237_core_ctrl: per-instruction vector table plus multi-cycle sequences.
module tb_ysyx_22040237_core_ctrl;

   localparam logic [31:0] RST_PC   = 32'h8000_0000;
   localparam int unsigned TO       = 16;
   localparam logic [31:0] I_ADDI   = 32'h0010_0093;
   localparam logic [31:0] I_EBREAK = 32'h0010_0073;
   localparam int unsigned NV       = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] inst, pc;
   logic [7:0]  dec_opcode;
   logic        dec_ebreak, dec_jump, dec_mem, dec_rd_w_en;
   logic [31:0] jump_target;
   logic        dmem_req_valid, dmem_req_ready, dmem_resp_valid;
   logic        rf_w_en, halt;
   logic [1:0]  halt_code;
   logic [63:0] cycle_cnt, instret_cnt;

   ysyx_22040237_core_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst            (inst),
      .pc              (pc),
      .dec_opcode      (dec_opcode),
      .dec_ebreak      (dec_ebreak),
      .dec_jump        (dec_jump),
      .dec_mem         (dec_mem),
      .dec_rd_w_en     (dec_rd_w_en),
      .jump_target     (jump_target),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_resp_valid (dmem_resp_valid),
      .rf_w_en         (rf_w_en),
      .halt            (halt),
      .halt_code       (halt_code),
      .cycle_cnt       (cycle_cnt),
      .instret_cnt     (instret_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] idata;
      logic [7:0]  op;
      logic        ebr, jmp, mem, rdw;
      logic [31:0] tgt;
      int unsigned ncyc;
      logic [31:0] e_pc;
      int unsigned e_rf;
      logic [63:0] e_ret, e_cyc;
      logic        e_halt;
      logic [1:0]  e_code;
   } vec_t;

   vec_t vt [NV];
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   function automatic vec_t mk(input string name, input logic [31:0] idata, input logic [7:0] op,
                               input logic ebr, input logic jmp, input logic mem, input logic rdw,
                               input logic [31:0] tgt, input int unsigned ncyc, input logic [31:0] e_pc,
                               input int unsigned e_rf, input logic [63:0] e_ret, input logic [63:0] e_cyc,
                               input logic e_halt, input logic [1:0] e_code);
      vec_t v;
      v.name = name; v.idata = idata; v.op = op; v.ebr = ebr; v.jmp = jmp; v.mem = mem; v.rdw = rdw;
      v.tgt = tgt; v.ncyc = ncyc; v.e_pc = e_pc; v.e_rf = e_rf; v.e_ret = e_ret; v.e_cyc = e_cyc;
      v.e_halt = e_halt; v.e_code = e_code;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nxt();
      rst = 1'b0;
   endtask

   task automatic zero_wait();
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b1;
      dmem_req_ready  = 1'b1;
      dmem_resp_valid = 1'b1;
   endtask

   task automatic set_dec(input logic [31:0] idata, input logic [7:0] op, input logic ebr, input logic jmp,
                          input logic mem, input logic rdw, input logic [31:0] tgt);
      imem_resp_data = idata;
      dec_opcode     = op;
      dec_ebreak     = ebr;
      dec_jump       = jmp;
      dec_mem        = mem;
      dec_rd_w_en    = rdw;
      jump_target    = tgt;
   endtask

   task automatic set_addi();
      set_dec(I_ADDI, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
   endtask

   initial begin
      int unsigned pulses;
      int unsigned hs;

      vt[0] = mk("addi",       I_ADDI,       8'h13, 0, 0, 0, 1, 32'h0,         4, 32'h8000_0004, 1, 1, 4, 0, 2'd0);
      vt[1] = mk("jal",        32'h1000_006F, 8'h6F, 0, 1, 0, 1, 32'h8000_0100, 4, 32'h8000_0100, 1, 1, 4, 0, 2'd0);
      vt[2] = mk("jalr_odd",   32'h0000_80E7, 8'h67, 0, 1, 0, 1, 32'h8000_0105, 4, 32'h8000_0104, 1, 1, 4, 0, 2'd0);
      vt[3] = mk("lw",         32'h0000_A103, 8'h03, 0, 0, 1, 1, 32'h0,         6, 32'h8000_0004, 1, 1, 6, 0, 2'd0);
      vt[4] = mk("sw",         32'h0020_A023, 8'h23, 0, 0, 1, 0, 32'h0,         6, 32'h8000_0004, 0, 1, 6, 0, 2'd0);
      vt[5] = mk("ebreak",     I_EBREAK,     8'h73, 1, 0, 0, 1, 32'h0,         6, RST_PC,        0, 0, 3, 1, 2'd1);
      vt[6] = mk("illegal",    32'hFFFF_FFFF, 8'h00, 0, 0, 0, 1, 32'h0,         6, RST_PC,        0, 0, 3, 1, 2'd2);
      vt[7] = mk("ebr_over_ill", I_EBREAK,   8'h00, 1, 0, 0, 1, 32'h0,         6, RST_PC,        0, 0, 3, 1, 2'd1);
      vt[8] = mk("misalign",   32'h0000_00E7, 8'h67, 0, 1, 1, 1, 32'h8000_0106, 6, RST_PC,        0, 0, 3, 1, 2'd2);
      vt[9] = mk("jmp_mem",    32'h0000_00E7, 8'h67, 0, 1, 1, 0, 32'h8000_0200, 6, 32'h8000_0200, 0, 1, 6, 0, 2'd0);

      zero_wait();
      set_addi();

      // Reset state
      do_reset();
      smp();
      check("rst pc", 64'(pc), 64'(RST_PC));
      check("rst inst", 64'(inst), 64'h0);
      check("rst halt", 64'(halt), 64'h0);
      check("rst halt_code", 64'(halt_code), 64'h0);
      check("rst cycle_cnt", cycle_cnt, 64'h0);
      check("rst instret_cnt", instret_cnt, 64'h0);
      check("rst imem_req_valid", 64'(imem_req_valid), 64'h1);
      check("rst dmem_req_valid", 64'(dmem_req_valid), 64'h0);
      check("rst rf_w_en", 64'(rf_w_en), 64'h0);

      // Single-instruction vector table
      for (int unsigned i = 0; i < NV; i++) begin
         do_reset();
         zero_wait();
         set_dec(vt[i].idata, vt[i].op, vt[i].ebr, vt[i].jmp, vt[i].mem, vt[i].rdw, vt[i].tgt);
         pulses = 0;
         for (int unsigned c = 0; c < vt[i].ncyc; c++) begin
            smp();
            if (rf_w_en) pulses++;
            nxt();
         end
         smp();
         check({vt[i].name, " pc"}, 64'(pc), 64'(vt[i].e_pc));
         check({vt[i].name, " inst"}, 64'(inst), 64'(vt[i].idata));
         check({vt[i].name, " rf pulses"}, 64'(pulses), 64'(vt[i].e_rf));
         check({vt[i].name, " instret"}, instret_cnt, vt[i].e_ret);
         check({vt[i].name, " cycle_cnt"}, cycle_cnt, vt[i].e_cyc);
         check({vt[i].name, " halt"}, 64'(halt), 64'(vt[i].e_halt));
         check({vt[i].name, " halt_code"}, 64'(halt_code), 64'(vt[i].e_code));
      end

      // addi stream: commit every 4th cycle
      do_reset();
      zero_wait();
      set_addi();
      for (int unsigned k = 0; k < 12; k++) begin
         smp();
         check($sformatf("stream rf_w_en c%0d", k), 64'(rf_w_en), 64'(k % 4 == 3));
         if (k % 4 == 0) check($sformatf("stream imem_addr c%0d", k), 64'(imem_addr), 64'(RST_PC + 32'(4 * (k / 4))));
         nxt();
      end
      smp();
      check("stream instret", instret_cnt, 64'd3);
      check("stream pc", 64'(pc), 64'h8000_000C);

      // Two addi then ebreak at 8000_0008
      do_reset();
      zero_wait();
      set_addi();
      for (int unsigned k = 0; k < 8; k++) nxt();
      set_dec(I_EBREAK, 8'h73, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      pulses = 0;
      for (int unsigned k = 8; k <= 16; k++) begin
         smp();
         if (rf_w_en) pulses++;
         if (k == 10) check("ebreak halt before EX end", 64'(halt), 64'h0);
         if (k == 11) begin
            check("ebreak halt", 64'(halt), 64'h1);
            check("ebreak code", 64'(halt_code), 64'd1);
            check("ebreak pc", 64'(pc), 64'h8000_0008);
            check("ebreak cycle_cnt", cycle_cnt, 64'd11);
         end
         if (k == 16) begin
            check("ebreak cycle frozen", cycle_cnt, 64'd11);
            check("ebreak instret frozen", instret_cnt, 64'd2);
            check("ebreak imem_req_valid", 64'(imem_req_valid), 64'h0);
            check("ebreak pc frozen", 64'(pc), 64'h8000_0008);
         end
         nxt();
      end
      check("ebreak rf pulses", 64'(pulses), 64'h0);

      // imem_req_ready stalled 5 cycles
      do_reset();
      zero_wait();
      set_addi();
      imem_req_ready = 1'b0;
      hs = 0;
      for (int unsigned k = 0; k < 9; k++) begin
         if (k == 5) imem_req_ready = 1'b1;
         smp();
         if (imem_req_valid && imem_req_ready) hs++;
         if (k < 5) begin
            check($sformatf("stall valid c%0d", k), 64'(imem_req_valid), 64'h1);
            check($sformatf("stall addr c%0d", k), 64'(imem_addr), 64'(RST_PC));
         end
         nxt();
      end
      smp();
      check("stall handshakes", 64'(hs), 64'd1);
      check("stall instret", instret_cnt, 64'd1);
      check("stall pc", 64'(pc), 64'h8000_0004);

      // Fetch response never arrives: timeout 16 cycles after IF_WAIT entry (cycle 1)
      do_reset();
      zero_wait();
      imem_resp_valid = 1'b0;
      for (int unsigned k = 0; k <= 16; k++) begin
         smp();
         if (k == 16) check("timeout halt at last wait cycle", 64'(halt), 64'h0);
         nxt();
      end
      smp();
      check("timeout halt", 64'(halt), 64'h1);
      check("timeout code", 64'(halt_code), 64'd3);
      check("timeout cycle_cnt", cycle_cnt, 64'd17);
      check("timeout pc", 64'(pc), 64'(RST_PC));

      // Response arrives in the expiry cycle: no timeout
      do_reset();
      zero_wait();
      set_addi();
      imem_resp_valid = 1'b0;
      for (int unsigned k = 0; k < 16; k++) nxt();
      imem_resp_valid = 1'b1;
      nxt();
      imem_resp_valid = 1'b0;
      smp();
      check("late resp halt", 64'(halt), 64'h0);
      check("late resp inst", 64'(inst), 64'(I_ADDI));
      nxt();
      nxt();
      smp();
      check("late resp instret", instret_cnt, 64'd1);
      check("late resp pc", 64'(pc), 64'h8000_0004);
      check("late resp halt after", 64'(halt), 64'h0);

      // Reset in the middle of MEM_WAIT
      do_reset();
      zero_wait();
      dmem_resp_valid = 1'b0;
      set_dec(32'h0000_A103, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      for (int unsigned k = 0; k < 5; k++) begin
         smp();
         if (k == 3) check("mem dmem_req_valid in MEM_REQ", 64'(dmem_req_valid), 64'h1);
         if (k == 4) check("mem dmem_req_valid in MEM_WAIT", 64'(dmem_req_valid), 64'h0);
         nxt();
      end
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      smp();
      check("mid rst imem_req_valid", 64'(imem_req_valid), 64'h1);
      check("mid rst pc", 64'(pc), 64'(RST_PC));
      check("mid rst cycle_cnt", cycle_cnt, 64'h0);
      check("mid rst instret", instret_cnt, 64'h0);
      check("mid rst dmem_req_valid", 64'(dmem_req_valid), 64'h0);
      check("mid rst halt", 64'(halt), 64'h0);
      nxt();

      // PC wraps modulo 2^32
      do_reset();
      zero_wait();
      set_dec(32'h0000_006F, 8'h6F, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      for (int unsigned k = 0; k < 4; k++) nxt();
      set_addi();
      for (int unsigned k = 0; k < 4; k++) nxt();
      smp();
      check("wrap pc", 64'(pc), 64'h0);
      check("wrap instret", instret_cnt, 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
